// File: rtl/bp_be_fe_queue_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_fe_queue_rx_pkg
// Description : Shared constants and helpers for the BE-side fe_queue
//               receiver. Packets stay opaque; only pointer sizing and
//               pointer arithmetic live here.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_be_fe_queue_rx_pkg;

    localparam int c_DEFAULT_ELS = 8;

    // Pointer width: index bits plus one wrap bit to tell full from empty
    function automatic int calc_ptr_w(input int els);
        return $clog2(els) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_be_fe_cmd_reg.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_fe_cmd_reg
// Description : One-entry valid/yumi register holding the fe_cmd packet
//               launched to the front end. A new command is accepted only
//               when empty, so there is always one bubble between commands.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_be_fe_cmd_reg #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_v,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_v,
    input  logic             i_yumi
);

    logic             r_v;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    assign o_ready = ~r_v & rst_n;
    assign w_load  = i_v & o_ready;

    // Valid flag: set on load, cleared when the front end consumes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
        end else if (w_load) begin
            r_v <= 1'b1;
        end else if (i_yumi) begin
            r_v <= 1'b0;
        end
    end

    // Payload needs no reset; it is only observed while valid
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_data <= i_data;
        end
    end

    assign o_v    = r_v;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/bp_be_fe_queue_rx.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_fe_queue_rx
// Description : BE endpoint of the FE/BE interface. Buffers fe_queue packets
//               in a replayable circular buffer (enqueue/issue/commit
//               pointers), presents the oldest unissued entry to issue, and
//               launches fe_cmd packets through a one-entry register.
//               Build option BP_BE_FE_QUEUE_ROLL_EN enables the commit
//               pointer and roll (replay); otherwise slots free at issue.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_be_fe_queue_rx
    import bp_be_fe_queue_rx_pkg::*;
#(
    parameter int fe_queue_width_p = 128,
    parameter int fe_cmd_width_p   = 96,
    parameter int els_p            = c_DEFAULT_ELS
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [fe_queue_width_p-1:0] fe_queue_i,
    input  logic                        fe_queue_v_i,
    output logic                        fe_queue_ready_o,
    output logic [fe_queue_width_p-1:0] issue_pkt_o,
    output logic                        issue_v_o,
    input  logic                        issue_yumi_i,
    input  logic                        commit_i,
    input  logic                        roll_i,
    input  logic                        clr_i,
    input  logic [fe_cmd_width_p-1:0]   cmd_i,
    input  logic                        cmd_v_i,
    output logic                        cmd_ready_o,
    output logic [fe_cmd_width_p-1:0]   fe_cmd_o,
    output logic                        fe_cmd_v_o,
    input  logic                        fe_cmd_yumi_i
);

    localparam int c_PTR_W = calc_ptr_w(els_p);
    localparam int c_IDX_W = c_PTR_W - 1;
    localparam logic [c_PTR_W-1:0] c_WRAP = {1'b1, {c_IDX_W{1'b0}}};

    logic [fe_queue_width_p-1:0] r_mem [els_p];
    logic [c_PTR_W-1:0]          r_wptr;
    logic [c_PTR_W-1:0]          r_rptr;
    logic [c_PTR_W-1:0]          w_cptr;
    logic                        w_full;
    logic                        w_enq;
    logic                        w_deq;

    assign w_enq = fe_queue_v_i & fe_queue_ready_o;
    assign w_deq = issue_yumi_i & issue_v_o;

`ifdef BP_BE_FE_QUEUE_ROLL_EN
    logic [c_PTR_W-1:0] r_cptr;
    logic [c_PTR_W-1:0] w_cptr_next;
    logic               w_cmt;

    assign w_cmt       = commit_i & (r_cptr != r_rptr);
    assign w_cptr_next = r_cptr + c_PTR_W'(w_cmt);
    assign w_cptr      = r_cptr;

    // Pointer update; roll rewinds issue to the post-commit boundary so the
    // ordering cptr <= rptr holds even with a same-cycle commit
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else begin
            r_wptr <= r_wptr + c_PTR_W'(w_enq);
            r_cptr <= w_cptr_next;
            if (roll_i) begin
                r_rptr <= w_cptr_next;
            end else begin
                r_rptr <= r_rptr + c_PTR_W'(w_deq);
            end
        end
    end

    a_commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        commit_i |-> (r_cptr != r_rptr));
`else
    // Without replay, a slot frees as soon as it issues
    assign w_cptr = r_rptr;

    logic w_unused;
    assign w_unused = commit_i ^ roll_i;

    // Pointer update; clear wins over enqueue and issue
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= r_wptr + c_PTR_W'(w_enq);
            r_rptr <= r_rptr + c_PTR_W'(w_deq);
        end
    end
`endif

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        issue_yumi_i |-> issue_v_o);

    assign w_full           = ((r_wptr ^ w_cptr) == c_WRAP);
    assign fe_queue_ready_o = ~w_full & ~fe_cmd_v_o & reset_n_i;
    assign issue_v_o        = (r_rptr != r_wptr) & reset_n_i;
    assign issue_pkt_o      = r_mem[r_rptr[c_IDX_W-1:0]];

    // Storage write; a packet arriving alongside a clear is dropped
    always_ff @(posedge clk_i) begin
        if (w_enq && !clr_i) begin
            r_mem[r_wptr[c_IDX_W-1:0]] <= fe_queue_i;
        end
    end

    bp_be_fe_cmd_reg #(
        .WIDTH (fe_cmd_width_p)
    ) u_cmd_reg (
        .clk     (clk_i),
        .rst_n   (reset_n_i),
        .i_data  (cmd_i),
        .i_v     (cmd_v_i),
        .o_ready (cmd_ready_o),
        .o_data  (fe_cmd_o),
        .o_v     (fe_cmd_v_o),
        .i_yumi  (fe_cmd_yumi_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_bp_be_fe_queue_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_be_fe_queue_rx
// Description : Directed self-checking bench for bp_be_fe_queue_rx.
//               Expectations adapt to BP_BE_FE_QUEUE_ROLL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_be_fe_queue_rx;

    logic         clk = 1'b0;
    logic         reset_n_i;
    logic [127:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [127:0] issue_pkt_o;
    logic         issue_v_o;
    logic         issue_yumi_i;
    logic         commit_i;
    logic         roll_i;
    logic         clr_i;
    logic [95:0]  cmd_i;
    logic         cmd_v_i;
    logic         cmd_ready_o;
    logic [95:0]  fe_cmd_o;
    logic         fe_cmd_v_o;
    logic         fe_cmd_yumi_i;

    int checks = 0;
    int errors = 0;

    bp_be_fe_queue_rx #(
        .fe_queue_width_p (128),
        .fe_cmd_width_p   (96),
        .els_p            (8)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .issue_pkt_o      (issue_pkt_o),
        .issue_v_o        (issue_v_o),
        .issue_yumi_i     (issue_yumi_i),
        .commit_i         (commit_i),
        .roll_i           (roll_i),
        .clr_i            (clr_i),
        .cmd_i            (cmd_i),
        .cmd_v_i          (cmd_v_i),
        .cmd_ready_o      (cmd_ready_o),
        .fe_cmd_o         (fe_cmd_o),
        .fe_cmd_v_o       (fe_cmd_v_o),
        .fe_cmd_yumi_i    (fe_cmd_yumi_i)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pkt(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(n);
        return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(n)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [95:0] c_CMD_A = 96'hA5A5_0000_1111_2222_3333_4444;
    localparam logic [95:0] c_CMD_B = 96'h0B0B_9999_8888_7777_6666_5555;

    initial begin : main
        int nexp;
        int outstanding;
        int k;

        reset_n_i     = 1'b0;
        fe_queue_i    = '0;
        fe_queue_v_i  = 1'b0;
        issue_yumi_i  = 1'b0;
        commit_i      = 1'b0;
        roll_i        = 1'b0;
        clr_i         = 1'b0;
        cmd_i         = '0;
        cmd_v_i       = 1'b0;
        fe_cmd_yumi_i = 1'b0;

        // Reset state
        #2;
        check("rst_issue_v", 128'(issue_v_o), 128'd0);
        check("rst_q_ready", 128'(fe_queue_ready_o), 128'd0);
        check("rst_cmd_ready", 128'(cmd_ready_o), 128'd0);
        check("rst_fe_cmd_v", 128'(fe_cmd_v_o), 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        step();
        check("post_rst_q_ready", 128'(fe_queue_ready_o), 128'd1);
        check("post_rst_cmd_ready", 128'(cmd_ready_o), 128'd1);
        check("empty_issue_v", 128'(issue_v_o), 128'd0);

        // Fill 8 back to back
        for (int i = 0; i < 8; i++) begin
            fe_queue_v_i = 1'b1;
            fe_queue_i   = pkt(i);
            step();
            if (i == 0) check("enq_latency_issue_v", 128'(issue_v_o), 128'd1);
            if (i < 7) check("fill_ready", 128'(fe_queue_ready_o), 128'd1);
        end
        check("full_ready", 128'(fe_queue_ready_o), 128'd0);
        fe_queue_i = pkt(8);
        step();
        step();
        check("full_hold_ready", 128'(fe_queue_ready_o), 128'd0);
        check("full_head_pkt", issue_pkt_o, pkt(0));
        fe_queue_v_i = 1'b0;

        // Issue 3, commit 1, roll
        issue_yumi_i = 1'b1;
        step();
        step();
        step();
        issue_yumi_i = 1'b0;
        check("issued3_pkt", issue_pkt_o, pkt(3));
`ifdef BP_BE_FE_QUEUE_ROLL_EN
        check("issued3_ready", 128'(fe_queue_ready_o), 128'd0);
`else
        check("issued3_ready", 128'(fe_queue_ready_o), 128'd1);
`endif
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        roll_i   = 1'b1;
        step();
        roll_i   = 1'b0;
        check("roll_issue_v", 128'(issue_v_o), 128'd1);
`ifdef BP_BE_FE_QUEUE_ROLL_EN
        check("roll_pkt", issue_pkt_o, pkt(1));
`else
        check("roll_pkt", issue_pkt_o, pkt(3));
`endif

        // Clear with simultaneous enqueue and yumi
        fe_queue_v_i = 1'b1;
        fe_queue_i   = pkt(99);
        issue_yumi_i = 1'b1;
        clr_i        = 1'b1;
        step();
        fe_queue_v_i = 1'b0;
        issue_yumi_i = 1'b0;
        clr_i        = 1'b0;
        check("clr_issue_v", 128'(issue_v_o), 128'd0);
        check("clr_ready", 128'(fe_queue_ready_o), 128'd1);
        step();
        check("clr_dropped_issue_v", 128'(issue_v_o), 128'd0);

        // Command register with delayed yumi; enqueue blocked while pending
        cmd_v_i = 1'b1;
        cmd_i   = c_CMD_A;
        step();
        cmd_i        = c_CMD_B;
        fe_queue_v_i = 1'b1;
        fe_queue_i   = pkt(77);
        for (int i = 0; i < 5; i++) begin
            check("cmd_hold_v", 128'(fe_cmd_v_o), 128'd1);
            check("cmd_hold_data", 128'(fe_cmd_o), 128'(c_CMD_A));
            check("cmd_hold_cmd_ready", 128'(cmd_ready_o), 128'd0);
            check("cmd_hold_q_ready", 128'(fe_queue_ready_o), 128'd0);
            step();
        end
        cmd_v_i       = 1'b0;
        fe_queue_v_i  = 1'b0;
        fe_cmd_yumi_i = 1'b1;
        step();
        fe_cmd_yumi_i = 1'b0;
        check("cmd_yumi_v", 128'(fe_cmd_v_o), 128'd0);
        check("cmd_yumi_cmd_ready", 128'(cmd_ready_o), 128'd1);
        check("cmd_yumi_q_ready", 128'(fe_queue_ready_o), 128'd1);
        check("cmd_blocked_enq", 128'(issue_v_o), 128'd0);

        // Streaming at rate 1 through pointer wrap
        nexp        = 0;
        outstanding = 0;
        for (int i = 0; i < 20; i++) begin
            fe_queue_v_i = 1'b1;
            fe_queue_i   = pkt(100 + i);
            check("stream_ready", 128'(fe_queue_ready_o), 128'd1);
            issue_yumi_i = issue_v_o;
            if (issue_v_o) begin
                check("stream_pkt", issue_pkt_o, pkt(100 + nexp));
                nexp++;
            end
`ifdef BP_BE_FE_QUEUE_ROLL_EN
            commit_i = (outstanding > 0);
            outstanding = outstanding + (issue_yumi_i ? 1 : 0) - (commit_i ? 1 : 0);
`endif
            step();
        end
        fe_queue_v_i = 1'b0;
        k = 0;
        while (nexp < 20 && k < 12) begin
            issue_yumi_i = issue_v_o;
            if (issue_v_o) begin
                check("drain_pkt", issue_pkt_o, pkt(100 + nexp));
                nexp++;
            end
`ifdef BP_BE_FE_QUEUE_ROLL_EN
            commit_i = (outstanding > 0);
            outstanding = outstanding + (issue_yumi_i ? 1 : 0) - (commit_i ? 1 : 0);
`endif
            step();
            k++;
        end
        issue_yumi_i = 1'b0;
`ifdef BP_BE_FE_QUEUE_ROLL_EN
        while (outstanding > 0) begin
            commit_i = 1'b1;
            outstanding--;
            step();
        end
`endif
        commit_i = 1'b0;
        check("stream_count", 128'(nexp), 128'd20);
        check("stream_empty", 128'(issue_v_o), 128'd0);

        // Asynchronous reset mid-stream
        fe_queue_v_i = 1'b1;
        fe_queue_i   = pkt(200);
        step();
        fe_queue_v_i = 1'b0;
        cmd_v_i      = 1'b1;
        cmd_i        = c_CMD_A;
        step();
        cmd_v_i = 1'b0;
        check("pre_rst_issue_v", 128'(issue_v_o), 128'd1);
        check("pre_rst_fe_cmd_v", 128'(fe_cmd_v_o), 128'd1);
        #3;
        reset_n_i = 1'b0;
        #1;
        check("async_rst_issue_v", 128'(issue_v_o), 128'd0);
        check("async_rst_fe_cmd_v", 128'(fe_cmd_v_o), 128'd0);
        check("async_rst_q_ready", 128'(fe_queue_ready_o), 128'd0);
        check("async_rst_cmd_ready", 128'(cmd_ready_o), 128'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        step();
        check("rel_issue_v", 128'(issue_v_o), 128'd0);
        check("rel_q_ready", 128'(fe_queue_ready_o), 128'd1);
        check("rel_cmd_ready", 128'(cmd_ready_o), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
